serial_word_packer: RTL and testbench

//  Upstream feeder for the 2-deep shift FIFO. Collects a serial bit stream through a

---
 rtl/serial_word_packer.sv | 155 +++++++++++++++
 tb/tb_serial_word_packer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_packer.sv
// ----------------------------------------------------------------------------
// serial_word_packer
//
// Collects a serial bit stream over a valid/ready handshake and packs it into
// DATA_WIDTH-bit words for a downstream shift FIFO. Each finished word is
// presented on word_out together with a one-cycle wr strobe. If the FIFO is
// full when a word completes, the word is parked and the bit source is
// stalled until the FIFO has room. A level flush emits a partial word, with
// the unfilled positions set to PAD_BIT.
//
// Ports
//   clk        in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   bit_in     in   serial data bit
//   bit_valid  in   bit_in is valid this cycle
//   bit_ready  out  packer accepts a bit this cycle (combinational)
//   flush      in   level request: emit the partial word, padded
//   fifo_full  in   downstream FIFO full flag
//   word_out   out  packed word (FIFO din), held until the next word
//   wr         out  one-cycle write strobe (FIFO wr)
//   bit_count  out  bits held: cnt in COLLECT, DATA_WIDTH in STALL
//   busy       out  bits are held or a word is parked
// ----------------------------------------------------------------------------
module serial_word_packer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter bit          MSB_FIRST  = 1'b0,
   parameter bit          PAD_BIT    = 1'b0
) (
   input  logic                                clk,
   input  logic                                resetn,
   input  logic                                bit_in,
   input  logic                                bit_valid,
   output logic                                bit_ready,
   input  logic                                flush,
   input  logic                                fifo_full,
   output logic [DATA_WIDTH-1:0]               word_out,
   output logic                                wr,
   output logic [$clog2(DATA_WIDTH+1)-1:0]     bit_count,
   output logic                                busy
);

   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DATA_WIDTH);

   typedef enum logic {
      S_COLLECT,
      S_STALL
   } state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic [DATA_WIDTH-1:0]   word_q, word_d;
   logic                    wr_q, wr_d;

   logic                    accept;
   logic                    complete;
   logic                    flush_now;
   logic [CW-1:0]           cnt_after;
   logic [DATA_WIDTH-1:0]   shift_acc;
   logic [DATA_WIDTH-1:0]   emit_word;

   // Arrival index of the bit that ends up in word position pos.
   function automatic int unsigned arrival_order(input int unsigned pos);
      return MSB_FIRST ? (DATA_WIDTH - 1 - pos) : pos;
   endfunction

   assign bit_ready = resetn && (state_q == S_COLLECT);
   assign accept    = bit_valid && bit_ready;
   assign cnt_after = cnt_q + {{(CW-1){1'b0}}, accept};
   assign complete  = accept && (cnt_q == LAST_CNT);

   // A flush that coincides with an accepted bit covers that bit too; a bit
   // that completes the word wins and the flush has nothing left to emit.
   assign flush_now = flush && (state_q == S_COLLECT) && !complete && (cnt_after != '0);

   // shift_acc inserts the incoming bit; emit_word pads every position that
   // has not yet arrived. For a completed word nothing is padded.
   always_comb begin
      shift_acc = shift_q;
      emit_word = '0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         if (accept && (arrival_order(i) == 32'(cnt_q))) begin
            shift_acc[i] = bit_in;
         end
      end
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         emit_word[i] = (arrival_order(i) < 32'(cnt_after)) ? shift_acc[i] : PAD_BIT;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      word_d  = word_q;
      wr_d    = 1'b0;
      case (state_q)
         S_COLLECT: begin
            if (accept) begin
               shift_d = shift_acc;
               cnt_d   = cnt_after;
            end
            if (complete || flush_now) begin
               cnt_d = '0;
               if (fifo_full) begin
                  // Park the finished word in the shift register.
                  state_d = S_STALL;
                  shift_d = emit_word;
               end else begin
                  word_d  = emit_word;
                  wr_d    = 1'b1;
                  shift_d = '0;
               end
            end
         end
         S_STALL: begin
            if (!fifo_full) begin
               word_d  = shift_q;
               wr_d    = 1'b1;
               shift_d = '0;
               state_d = S_COLLECT;
            end
         end
         default: begin
            state_d = S_COLLECT;
            cnt_d   = '0;
            shift_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_COLLECT;
         cnt_q   <= '0;
         shift_q <= '0;
         word_q  <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         wr_q    <= wr_d;
      end
   end

   assign word_out  = word_q;
   assign wr        = wr_q;
   assign bit_count = (state_q == S_STALL) ? FULL_CNT : cnt_q;
   assign busy      = (state_q == S_STALL) || (cnt_q != '0);

endmodule

// File: tb/tb_serial_word_packer.sv
// ----------------------------------------------------------------------------
// tb_serial_word_packer
//
// Drives two packers (LSB-first and MSB-first) with the same stimulus. Words
// expected from each are queued when the completing bit or flush is driven and
// are popped whenever the matching instance pulses wr.
// ----------------------------------------------------------------------------
module tb_serial_word_packer;

   logic       clk = 1'b0;
   logic       resetn;
   logic       bit_in;
   logic       bit_valid;
   logic       flush;
   logic       fifo_full;

   logic       bit_ready,   bit_ready_m;
   logic [7:0] word_out,    word_out_m;
   logic       wr,          wr_m;
   logic [3:0] bit_count,   bit_count_m;
   logic       busy,        busy_m;

   int checks = 0;
   int errors = 0;

   logic [7:0] q_lsb[$];
   logic [7:0] q_msb[$];

   typedef struct {
      logic [7:0] seq;      // seq[0] is sent first
      logic [7:0] exp_lsb;
      logic [7:0] exp_msb;
   } vec_t;

   vec_t tbl[6];

   serial_word_packer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .PAD_BIT(1'b0)) dut (
      .clk(clk), .resetn(resetn), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(bit_ready), .flush(flush), .fifo_full(fifo_full),
      .word_out(word_out), .wr(wr), .bit_count(bit_count), .busy(busy)
   );

   serial_word_packer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .PAD_BIT(1'b0)) dut_m (
      .clk(clk), .resetn(resetn), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(bit_ready_m), .flush(flush), .fifo_full(fifo_full),
      .word_out(word_out_m), .wr(wr_m), .bit_count(bit_count_m), .busy(busy_m)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] e_lsb, input logic [7:0] e_msb);
      q_lsb.push_back(e_lsb);
      q_msb.push_back(e_msb);
   endtask

   // Drives bits seq[from..to-1] on consecutive cycles; queues the word when
   // bit 7 is driven.
   task automatic send_bits(input logic [7:0] seq, input int from, input int to,
                            input logic [7:0] e_lsb, input logic [7:0] e_msb);
      logic [7:0] s;
      s = seq;
      for (int i = from; i < to; i++) begin
         chk("ready_while_streaming", 32'(bit_ready), 1);
         bit_valid = 1'b1;
         bit_in    = s[i];
         if (i == 7) push_exp(e_lsb, e_msb);
         @(posedge clk);
         #1;
         bit_valid = 1'b0;
      end
   endtask

   // Scoreboard: every wr must match the oldest queued word.
   always @(negedge clk) begin
      if (resetn && wr) begin
         chk("wr_lsb_has_expected", 32'(q_lsb.size() != 0), 1);
         if (q_lsb.size() != 0) chk("word_lsb", 32'(word_out), 32'(q_lsb.pop_front()));
      end
      if (resetn && wr_m) begin
         chk("wr_msb_has_expected", 32'(q_msb.size() != 0), 1);
         if (q_msb.size() != 0) chk("word_msb", 32'(word_out_m), 32'(q_msb.pop_front()));
      end
   end

   initial begin
      tbl[0] = '{seq: 8'h03, exp_lsb: 8'h03, exp_msb: 8'hC0};
      tbl[1] = '{seq: 8'hA5, exp_lsb: 8'hA5, exp_msb: 8'hA5};
      tbl[2] = '{seq: 8'h3C, exp_lsb: 8'h3C, exp_msb: 8'h3C};
      tbl[3] = '{seq: 8'h01, exp_lsb: 8'h01, exp_msb: 8'h80};
      tbl[4] = '{seq: 8'hF0, exp_lsb: 8'hF0, exp_msb: 8'h0F};
      tbl[5] = '{seq: 8'h12, exp_lsb: 8'h12, exp_msb: 8'h48};

      resetn    = 1'b0;
      bit_in    = 1'b1;
      bit_valid = 1'b1;
      flush     = 1'b0;
      fifo_full = 1'b0;

      // Reset held with a valid source.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_word_out", 32'(word_out), 0);
      chk("rst_wr", 32'(wr), 0);
      chk("rst_bit_ready", 32'(bit_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_bit_count", 32'(bit_count), 0);
      chk("rst_bit_ready_m", 32'(bit_ready_m), 0);
      bit_valid = 1'b0;
      resetn    = 1'b1;
      #1;
      chk("post_rst_bit_ready", 32'(bit_ready), 1);
      @(posedge clk);
      #1;

      // Table: continuous words, wr one cycle after each 8th bit.
      for (int n = 0; n < 6; n++) begin
         send_bits(tbl[n].seq, 0, 8, tbl[n].exp_lsb, tbl[n].exp_msb);
         @(negedge clk);
         chk("wr_after_8th_bit", 32'(wr), 1);
         chk("wr_m_after_8th_bit", 32'(wr_m), 1);
         chk("count_zero_after_word", 32'(bit_count), 0);
      end
      @(negedge clk);
      chk("wr_single_cycle", 32'(wr), 0);
      @(posedge clk);
      #1;

      // Stall: FIFO full on the 8th bit for 3 cycles; flush during stall ignored.
      send_bits(8'h0B, 0, 7, 8'h00, 8'h00);
      fifo_full = 1'b1;
      bit_valid = 1'b1;
      bit_in    = 1'b0;
      push_exp(8'h0B, 8'hD0);
      @(posedge clk);
      #1;
      bit_in = 1'b1;
      flush  = 1'b1;
      @(negedge clk);
      chk("stall_ready", 32'(bit_ready), 0);
      chk("stall_wr", 32'(wr), 0);
      chk("stall_count", 32'(bit_count), 8);
      chk("stall_busy", 32'(busy), 1);
      chk("stall_count_m", 32'(bit_count_m), 8);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("stall_wr_2", 32'(wr), 0);
      @(posedge clk);
      #1;
      flush     = 1'b0;
      fifo_full = 1'b0;
      @(negedge clk);
      chk("stall_exit_ready", 32'(bit_ready), 0);
      chk("stall_exit_wr", 32'(wr), 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("stall_release_wr", 32'(wr), 1);
      chk("stall_release_ready", 32'(bit_ready), 1);
      chk("stall_release_count", 32'(bit_count), 0);
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      chk("held_bit_taken_count", 32'(bit_count), 1);
      send_bits(8'hE1, 1, 8, 8'hE1, 8'h87);
      @(negedge clk);
      chk("post_stall_word_wr", 32'(wr), 1);
      @(posedge clk);
      #1;

      // Flush of a 3-bit partial word, then flush with nothing held.
      send_bits(8'h03, 0, 3, 8'h00, 8'h00);
      chk("partial_count", 32'(bit_count), 3);
      chk("partial_busy", 32'(busy), 1);
      flush = 1'b1;
      push_exp(8'h03, 8'hC0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_wr", 32'(wr), 1);
      chk("flush_count", 32'(bit_count), 0);
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("empty_flush_no_wr", 32'(wr), 0);
      chk("empty_flush_busy", 32'(busy), 0);

      // Flush together with a non-completing bit includes that bit.
      send_bits(8'h05, 0, 2, 8'h00, 8'h00);
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      flush     = 1'b1;
      push_exp(8'h05, 8'hA0);
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      flush     = 1'b0;
      @(negedge clk);
      chk("flush_with_bit_wr", 32'(wr), 1);

      // Flush together with the completing bit: exactly one word.
      @(posedge clk);
      #1;
      send_bits(8'h12, 0, 7, 8'h00, 8'h00);
      bit_valid = 1'b1;
      bit_in    = 1'b0;
      flush     = 1'b1;
      push_exp(8'h12, 8'h48);
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      @(negedge clk);
      chk("flush_on_last_wr", 32'(wr), 1);
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_on_last_no_extra", 32'(wr), 0);
      @(posedge clk);
      #1;

      // Reset mid-word discards the partial bits.
      send_bits(8'hFF, 0, 5, 8'h00, 8'h00);
      resetn = 1'b0;
      #1;
      chk("midrst_word_out", 32'(word_out), 0);
      chk("midrst_word_out_m", 32'(word_out_m), 0);
      chk("midrst_wr", 32'(wr), 0);
      chk("midrst_count", 32'(bit_count), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_ready", 32'(bit_ready), 0);
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      send_bits(8'hFF, 0, 8, 8'hFF, 8'hFF);
      @(negedge clk);
      chk("after_rst_word_wr", 32'(wr), 1);

      repeat (3) @(negedge clk);
      chk("queue_lsb_drained", 32'(q_lsb.size()), 0);
      chk("queue_msb_drained", 32'(q_msb.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
